// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch responder.
// Optional fetch/stall statistics are enabled with IMEM_STATS_EN.
package imem_pkg;

  localparam int CNT_W = 4;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch bus between the program counter (master) and the imem responder.
// Optional fetch/stall statistics are enabled with IMEM_STATS_EN.
interface imem_fetch_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] pc_addr;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              hold;
  logic              misalign_err;

  modport master (
    output pc_addr,
    output flush,
    input  instr,
    input  instr_valid,
    input  hold,
    input  misalign_err
  );

  modport slave (
    input  pc_addr,
    input  flush,
    output instr,
    output instr_valid,
    output hold,
    output misalign_err
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous read port, one write port.
// Optional fetch/stall statistics are enabled with IMEM_STATS_EN.
module imem_array #(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [DATA_W-1:0]     wr_data
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rd_data_q;

  // Same-edge read sees the word before the write lands
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Fetch responder: captures PC, stalls for wait states, returns instr.
// Optional fetch/stall statistics are enabled with IMEM_STATS_EN.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  imem_fetch_responder_if.slave bus
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  hold_q, hold_d;
  logic                  valid_q, valid_d;
  logic                  mis_q, mis_d;
  logic                  nop_q, nop_d;

  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DATA_W-1:0]     rd_data;

  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic                  misalign;
  logic                  unused_pc_hi;

  assign fetch_idx    = bus.pc_addr[DEPTH_LOG2+1:2];
  assign misalign     = |bus.pc_addr[1:0];
  assign unused_pc_hi = ^bus.pc_addr[ADDR_W-1:DEPTH_LOG2+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    mis_d   = 1'b0;
    nop_d   = nop_q;
    rd_en   = 1'b0;
    rd_idx  = fetch_idx;
    case (state_q)
      WAIT: begin
        rd_idx = idx_q;
        cnt_d  = cnt_q - CNT_W'(1);
        if (bus.flush) begin
          state_d = IDLE;
          hold_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          hold_d  = 1'b0;
          valid_d = 1'b1;
          nop_d   = 1'b0;
          rd_en   = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both capture a new address
        idx_d = fetch_idx;
        if (misalign) begin
          state_d = DONE;
          hold_d  = 1'b0;
          valid_d = 1'b1;
          mis_d   = 1'b1;
          nop_d   = 1'b1;
        end else if (WAIT_STATES == 0) begin
          state_d = DONE;
          hold_d  = 1'b0;
          valid_d = 1'b1;
          nop_d   = 1'b0;
          rd_en   = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(WAIT_STATES);
          hold_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      nop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      nop_q   <= nop_d;
    end
  end

  imem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en & ~reset),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (ld_we),
    .wr_idx  (ld_addr),
    .wr_data (ld_data)
  );

  // instr is the read register unless the last event forced a NOP
  assign bus.instr        = nop_q ? NOP_WORD : rd_data;
  assign bus.instr_valid  = valid_q;
  assign bus.hold         = hold_q;
  assign bus.misalign_err = mis_q;

`ifdef IMEM_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (valid_q && fetch_cnt_q != '1)
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (hold_q && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder (WAIT_STATES 2 and 0).
// Stats checks are included when IMEM_STATS_EN is defined.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

`ifdef IMEM_STATS_EN
  logic [31:0] fc2, sc2, fc0, sc0;
`endif

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;

  logic [8:0]  exp_v = 9'b100_100_100;
  logic [31:0] exp_w [3] = '{32'h2008_0005, 32'h1111_1111,
                             32'h2222_2222};

  always #5 clk = ~clk;

  imem_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
  imem_fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

  imem_fetch_responder #(.WAIT_STATES(2)) u_ws2 (
    .clk       (clk),
    .reset     (reset),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .bus       (bus2)
`ifdef IMEM_STATS_EN
    ,
    .fetch_cnt (fc2),
    .stall_cnt (sc2)
`endif
  );

  imem_fetch_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk       (clk),
    .reset     (reset),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .bus       (bus0)
`ifdef IMEM_STATS_EN
    ,
    .fetch_cnt (fc0),
    .stall_cnt (sc0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] idx, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = idx;
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    ld_we        = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
    bus2.pc_addr = '0;
    bus2.flush   = 1'b0;
    bus0.pc_addr = '0;
    bus0.flush   = 1'b0;

    // program load while held in reset
    load(8'd0,  32'h2008_0005);
    load(8'd1,  32'h1111_1111);
    load(8'd2,  32'h2222_2222);
    load(8'd3,  32'h3333_3333);
    load(8'd16, 32'h1616_1616);
    tick();

    chk("rst_hold2",  bus2.hold,         0);
    chk("rst_valid2", bus2.instr_valid,  0);
    chk("rst_instr2", bus2.instr,        32'h0);
    chk("rst_mis2",   bus2.misalign_err, 0);
    chk("rst_hold0",  bus0.hold,         0);
    chk("rst_instr0", bus0.instr,        32'h0);
`ifdef IMEM_STATS_EN
    chk("rst_fcnt",   fc2, 0);
    chk("rst_scnt",   sc2, 0);
`endif

    // sequential fetch of 0, 4, 8
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("seq_valid%0d", i), bus2.instr_valid, exp_v[i]);
      chk($sformatf("seq_hold%0d", i),  bus2.hold, !exp_v[i]);
      pulses += int'(bus2.instr_valid);
      if (exp_v[i]) begin
        chk($sformatf("seq_instr%0d", i), bus2.instr, exp_w[i/3]);
        bus2.pc_addr = bus2.pc_addr + 32'd4;
      end
    end
    chk("seq_pulses", pulses, 3);

    // flush on the second wait cycle of the fetch at 0x10
    bus2.pc_addr = 32'h10;
    tick();
    chk("fl_hold_w1", bus2.hold, 1);
    tick();
    chk("fl_hold_w2",  bus2.hold,        1);
    chk("fl_valid_w2", bus2.instr_valid, 0);
    bus2.flush   = 1'b1;
    bus2.pc_addr = 32'h40;
    tick();
    chk("fl_hold",  bus2.hold,        0);
    chk("fl_valid", bus2.instr_valid, 0);
    chk("fl_instr", bus2.instr,       32'h2222_2222);
    bus2.flush = 1'b0;
    tick();
    chk("x40_hold1", bus2.hold, 1);
    tick();
    chk("x40_valid_early", bus2.instr_valid, 0);
    tick();
    chk("x40_valid", bus2.instr_valid, 1);
    chk("x40_instr", bus2.instr,       32'h1616_1616);
    chk("x40_hold",  bus2.hold,        0);

    // misaligned fetch
    bus2.pc_addr = 32'h6;
    tick();
    chk("mis_err",   bus2.misalign_err, 1);
    chk("mis_valid", bus2.instr_valid,  1);
    chk("mis_instr", bus2.instr,        32'h0);
    chk("mis_hold",  bus2.hold,         0);
    bus2.pc_addr = 32'h0;
    tick();
    chk("mis_pulse", bus2.misalign_err, 0);
    chk("w_valid",   bus2.instr_valid,  0);
    chk("w_hold",    bus2.hold,         1);
`ifdef IMEM_STATS_EN
    chk("st_fcnt", fc2, 5);
    chk("st_scnt", sc2, 10);
`endif

    // reset in the middle of a wait
    reset = 1'b1;
    tick();
    chk("mr_hold",  bus2.hold,         0);
    chk("mr_valid", bus2.instr_valid,  0);
    chk("mr_instr", bus2.instr,        32'h0);
    chk("mr_mis",   bus2.misalign_err, 0);
`ifdef IMEM_STATS_EN
    chk("mr_fcnt",  fc2, 0);
    chk("mr_scnt",  sc2, 0);
    chk("mr_fcnt0", fc0, 0);
    chk("mr_scnt0", sc0, 0);
`endif

    // zero wait states, write to index 3 while fetching 12
    reset        = 1'b0;
    bus0.pc_addr = 32'd12;
    bus2.pc_addr = 32'd12;
    ld_we        = 1'b1;
    ld_addr      = 8'd3;
    ld_data      = 32'hDEAD_BEEF;
    tick();
    ld_we = 1'b0;
    chk("z_valid", bus0.instr_valid, 1);
    chk("z_old",   bus0.instr,       32'h3333_3333);
    chk("z_hold",  bus0.hold,        0);
    tick();
    chk("z_valid2", bus0.instr_valid, 1);
    chk("z_new",    bus0.instr,       32'hDEAD_BEEF);
    chk("z_hold2",  bus0.hold,        0);
    tick();
    chk("w2_valid", bus2.instr_valid, 1);
    chk("w2_new",   bus2.instr,       32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
